// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad entry block.
// Holds the FSM state encoding, the keypad command codes and the
// credential field widths used by the interface, top and bench.
package atm_pkg;

    localparam int unsigned ACC_WIDTH = 12;
    localparam int unsigned PIN_WIDTH = 4;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        StIdle,
        StAccEntry,
        StPinEntry,
        StRequest,
        StWaitAuth,
        StSession,
        StLocked
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Keypad / authentication bundle between the keypad front-end and its
// neighbours.
//   master : drives keypad strobes, auth result, session_end; observes credentials
//   slave  : the keypad entry block itself
interface atm_keypad_entry_if;
    import atm_pkg::*;

    logic                 key_valid;
    logic [3:0]           key_code;
    logic                 auth_done;
    logic                 auth_ok;
    logic                 session_end;
    logic [ACC_WIDTH-1:0] acc_number;
    logic [PIN_WIDTH-1:0] pin;
    logic                 req_valid;
    logic                 in_session;
    logic                 locked;
    logic                 entry_error;
    logic [3:0]           fail_count;

    modport master (
        output key_valid, key_code, auth_done, auth_ok, session_end,
        input  acc_number, pin, req_valid, in_session, locked, entry_error, fail_count
    );

    modport slave (
        input  key_valid, key_code, auth_done, auth_ok, session_end,
        output acc_number, pin, req_valid, in_session, locked, entry_error, fail_count
    );

endinterface

// File: rtl/atm_cycle_counter.sv
// Loadable down-counter with a terminal flag.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i (has priority over en_i)
//   en_i        : decrement while non-zero
//   done_o      : count has reached zero
module atm_cycle_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad front-end: assembles a decimal account number and a one-digit
// PIN, issues one authentication request per attempt, tracks consecutive
// failures and locks the keypad for LOCKOUT_CYCLES after MAX_TRIES of them.
//   clk, rst_n : clock, async active-low reset
//   bus        : keypad/auth bundle (slave side)
// Optional build macro ATM_KEY_TIMEOUT_EN: abandons an entry after
// TIMEOUT_CYCLES without a key press.
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int unsigned ACC_DIGITS     = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                clk,
    input logic                rst_n,
    atm_keypad_entry_if.slave  bus
);

    localparam int unsigned CntMax =
        (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);

    state_e      state_q, state_d;
    // 14 bits so a 4-digit entry above 4095 is still detectable at ENTER.
    logic [13:0] acc_q, acc_d;
    logic [3:0]  pin_q, pin_d;
    logic [2:0]  digit_cnt_q, digit_cnt_d;
    logic        pin_held_q, pin_held_d;
    logic [3:0]  fail_q, fail_d;
    logic        err_q, err_d;

    logic            cnt_load, cnt_en, cnt_done;
    logic [CntW-1:0] cnt_val;

    logic        key_digit;
    logic [13:0] acc_mac;
    logic [3:0]  fail_inc;

    assign key_digit = bus.key_valid && is_digit(bus.key_code);
    assign acc_mac   = (acc_q * 14'd10) + {10'd0, bus.key_code};
    assign fail_inc  = fail_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pin_d       = pin_q;
        digit_cnt_d = digit_cnt_q;
        pin_held_d  = pin_held_q;
        fail_d      = fail_q;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (key_digit) begin
                    acc_d       = {10'd0, bus.key_code};
                    digit_cnt_d = 3'd1;
                    state_d     = StAccEntry;
                end
            end
            StAccEntry: begin
                if (key_digit) begin
                    if (digit_cnt_q < 3'(ACC_DIGITS)) begin
                        acc_d       = acc_mac;
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end else if (bus.key_valid) begin
                    if (bus.key_code == KEY_ENTER) begin
                        if (digit_cnt_q != 3'(ACC_DIGITS)) begin
                            err_d = 1'b1;
                        end else if (acc_q > 14'd4095) begin
                            err_d       = 1'b1;
                            acc_d       = '0;
                            digit_cnt_d = '0;
                            state_d     = StIdle;
                        end else begin
                            pin_d      = '0;
                            pin_held_d = 1'b0;
                            state_d    = StPinEntry;
                        end
                    end else if (bus.key_code == KEY_CLEAR) begin
                        acc_d       = '0;
                        digit_cnt_d = '0;
                    end else if (bus.key_code == KEY_CANCEL) begin
                        acc_d       = '0;
                        digit_cnt_d = '0;
                        state_d     = StIdle;
                    end
                end
            end
            StPinEntry: begin
                if (key_digit) begin
                    pin_d      = bus.key_code;
                    pin_held_d = 1'b1;
                end else if (bus.key_valid) begin
                    if (bus.key_code == KEY_ENTER) begin
                        if (pin_held_q) state_d = StRequest;
                        else            err_d   = 1'b1;
                    end else if (bus.key_code == KEY_CLEAR) begin
                        pin_d      = '0;
                        pin_held_d = 1'b0;
                    end else if (bus.key_code == KEY_CANCEL) begin
                        acc_d       = '0;
                        pin_d       = '0;
                        digit_cnt_d = '0;
                        pin_held_d  = 1'b0;
                        state_d     = StIdle;
                    end
                end
            end
            StRequest: begin
                state_d = StWaitAuth;
            end
            StWaitAuth: begin
                if (bus.auth_done) begin
                    if (bus.auth_ok) begin
                        fail_d  = '0;
                        state_d = StSession;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == 4'(MAX_TRIES)) begin
                            state_d = StLocked;
                        end else begin
                            pin_d      = '0;
                            pin_held_d = 1'b0;
                            state_d    = StPinEntry;
                        end
                    end
                end
            end
            StSession: begin
                if (bus.session_end) begin
                    acc_d       = '0;
                    pin_d       = '0;
                    digit_cnt_d = '0;
                    pin_held_d  = 1'b0;
                    state_d     = StIdle;
                end
            end
            StLocked: begin
                if (cnt_done) begin
                    fail_d      = '0;
                    acc_d       = '0;
                    pin_d       = '0;
                    digit_cnt_d = '0;
                    pin_held_d  = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef ATM_KEY_TIMEOUT_EN
        if ((state_q == StAccEntry || state_q == StPinEntry) && !bus.key_valid && cnt_done) begin
            err_d       = 1'b1;
            acc_d       = '0;
            pin_d       = '0;
            digit_cnt_d = '0;
            pin_held_d  = 1'b0;
            state_d     = StIdle;
        end
`endif
    end

    // The counter is reloaded on every state change so it always starts fresh
    // for whichever state is being entered.
    always_comb begin
        cnt_load = (state_d != state_q);
        cnt_val  = CntW'(LOCKOUT_CYCLES - 1);
        cnt_en   = (state_q == StLocked);
`ifdef ATM_KEY_TIMEOUT_EN
        if (state_d != StLocked) cnt_val = CntW'(TIMEOUT_CYCLES - 1);
        if (bus.key_valid && (state_q == StAccEntry || state_q == StPinEntry)) cnt_load = 1'b1;
        if (state_q == StAccEntry || state_q == StPinEntry) cnt_en = 1'b1;
`endif
    end

    atm_cycle_counter #(
        .Width(CntW)
    ) u_cycle_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            pin_q       <= '0;
            digit_cnt_q <= '0;
            pin_held_q  <= 1'b0;
            fail_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pin_q       <= pin_d;
            digit_cnt_q <= digit_cnt_d;
            pin_held_q  <= pin_held_d;
            fail_q      <= fail_d;
            err_q       <= err_d;
        end
    end

    assign bus.acc_number  = acc_q[ACC_WIDTH-1:0];
    assign bus.pin         = pin_q;
    assign bus.req_valid   = (state_q == StRequest);
    assign bus.in_session  = (state_q == StSession);
    assign bus.locked      = (state_q == StLocked);
    assign bus.entry_error = err_q;
    assign bus.fail_count  = fail_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed self-checking bench for atm_keypad_entry. Expected credentials are
// queued when the PIN ENTER is driven and compared on each req_valid pulse.
module tb_atm_keypad_entry;
    import atm_pkg::*;

    logic clk;
    logic rst_n;

    atm_keypad_entry_if bus ();

    atm_keypad_entry dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int pin;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    int   req_cnt = 0;
    int   err_cnt = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every request must match the oldest queued credentials.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_valid) begin
                req_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("req_acc", int'(bus.acc_number), e.acc);
                    check("req_pin", int'(bus.pin), e.pin);
                end
            end
            if (bus.entry_error) err_cnt++;
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic pin_attempt(input int acc, input logic [3:0] p);
        press(p);
        exp_q.push_back('{acc: acc, pin: int'(p)});
        press(KEY_ENTER);
    endtask

    task automatic auth(input logic ok);
        repeat (2) @(negedge clk);
        bus.auth_done = 1'b1;
        bus.auth_ok   = ok;
        @(negedge clk);
        bus.auth_done = 1'b0;
        bus.auth_ok   = 1'b0;
    endtask

    initial begin
        int e0;
        int r0;
        int n;

        rst_n            = 1'b0;
        bus.key_valid    = 1'b0;
        bus.key_code     = 4'h0;
        bus.auth_done    = 1'b0;
        bus.auth_ok      = 1'b0;
        bus.session_end  = 1'b0;
        #1;
        check("rst_acc", int'(bus.acc_number), 0);
        check("rst_pin", int'(bus.pin), 0);
        check("rst_req", int'(bus.req_valid), 0);
        check("rst_sess", int'(bus.in_session), 0);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_err", int'(bus.entry_error), 0);
        check("rst_fail", int'(bus.fail_count), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Successful login 2749 / 5
        press(4'd2); press(4'd7); press(4'd4); press(4'd9);
        check("acc_2749", int'(bus.acc_number), 2749);
        press(KEY_ENTER);
        pin_attempt(2749, 4'd5);
        auth(1'b1);
        check("sess_in", int'(bus.in_session), 1);
        check("sess_fail", int'(bus.fail_count), 0);
        check("sess_acc", int'(bus.acc_number), 2749);
        check("sess_pin", int'(bus.pin), 5);
        check("one_req", req_cnt, 1);
        check("q_empty1", exp_q.size(), 0);

        // session_end returns to IDLE with credentials cleared
        @(negedge clk);
        bus.session_end = 1'b1;
        @(negedge clk);
        bus.session_end = 1'b0;
        check("end_sess", int'(bus.in_session), 0);
        check("end_acc", int'(bus.acc_number), 0);
        check("end_pin", int'(bus.pin), 0);

        // Overflowing account number
        e0 = err_cnt;
        press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(KEY_ENTER);
        @(negedge clk);
        check("ovf_err", err_cnt - e0, 1);
        check("ovf_acc", int'(bus.acc_number), 0);
        press(KEY_ENTER);  // ignored in IDLE
        @(negedge clk);
        check("ovf_idle", err_cnt - e0, 1);
        check("ovf_noreq", req_cnt, 1);

        // Three failures -> lockout
        press(4'd2); press(4'd1); press(4'd7); press(4'd5); press(KEY_ENTER);
        for (int i = 1; i <= 3; i++) begin
            pin_attempt(2175, 4'd3);
            auth(1'b0);
            check("fail_cnt", int'(bus.fail_count), i);
        end
        check("lock_on", int'(bus.locked), 1);
        e0 = err_cnt;
        r0 = req_cnt;
        n  = 1;
        for (int i = 0; i < 2000; i++) begin
            bus.key_valid = (i % 5 == 0);
            bus.key_code  = (i % 10 == 0) ? KEY_ENTER : 4'(i % 10);
            @(negedge clk);
            if (!bus.locked) break;
            n++;
        end
        bus.key_valid = 1'b0;
        check("lock_len", n, 1024);
        check("lock_fail0", int'(bus.fail_count), 0);
        check("lock_off", int'(bus.locked), 0);
        check("lock_noerr", err_cnt - e0, 0);
        check("lock_noreq", req_cnt - r0, 0);
        check("q_empty2", exp_q.size(), 0);

        // Short account, then cancel from PIN entry after one failure
        e0 = err_cnt;
        press(4'd2); press(4'd1); press(KEY_ENTER);
        @(negedge clk);
        check("short_err", err_cnt - e0, 1);
        check("short_acc", int'(bus.acc_number), 21);
        press(4'd7); press(4'd5);
        check("acc_2175", int'(bus.acc_number), 2175);
        press(KEY_ENTER);
        pin_attempt(2175, 4'd8);
        auth(1'b0);
        check("retry_fail", int'(bus.fail_count), 1);
        check("retry_pin", int'(bus.pin), 0);
        press(KEY_CANCEL);
        check("cancel_acc", int'(bus.acc_number), 0);
        check("cancel_fail", int'(bus.fail_count), 1);

        // Reset in the middle of PIN entry
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER); press(4'd6);
        check("pre_rst_pin", int'(bus.pin), 6);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_acc", int'(bus.acc_number), 0);
        check("mid_rst_pin", int'(bus.pin), 0);
        check("mid_rst_fail", int'(bus.fail_count), 0);
        check("mid_rst_err", int'(bus.entry_error), 0);
        check("mid_rst_req", int'(bus.req_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = req_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_noreq", req_cnt - r0, 0);

        // Inactivity during account entry
        press(4'd2); press(4'd6);
        e0 = err_cnt;
`ifdef ATM_KEY_TIMEOUT_EN
        n = 0;
        while (err_cnt == e0 && n < 4300) begin
            @(negedge clk);
            n++;
        end
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_not_early", int'(n >= 4090), 1);
        check("tmo_acc", int'(bus.acc_number), 0);
        press(KEY_ENTER);  // ignored once back in IDLE
        @(negedge clk);
        check("tmo_idle", err_cnt - e0, 1);
`else
        repeat (10000) @(negedge clk);
        check("no_tmo_err", err_cnt - e0, 0);
        check("no_tmo_acc", int'(bus.acc_number), 26);
`endif
        check("q_empty_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
Front-end stage directly upstream of the ATM controller. It collects decimal keypad presses and assembles a 12-bit account number and a 4-bit single-digit PIN. It issues one authentication request per attempt and counts failed attempts, locking the keypad after too many failures. It holds the credentials stable for the whole session until the session ends.

Parameters:
ACC_DIGITS, 4, number of decimal digits in an account number (1..4)
MAX_TRIES, 3, consecutive failed authentications before lockout (1..15)
LOCKOUT_CYCLES, 1024, clk cycles spent in LOCKED before returning to IDLE
TIMEOUT_CYCLES, 4096, inactivity limit used only when ATM_KEY_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe; key_code is valid this cycle
key_code  in  4  0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC CANCEL, 4'hD-4'hF ignored
auth_done  in  1  one-cycle strobe from downstream; auth_ok is valid this cycle
auth_ok  in  1  1 = credentials accepted
session_end  in  1  exit request from downstream; level-sensitive
acc_number  out  12  assembled account number in binary
pin  out  4  entered PIN digit
req_valid  out  1  one-cycle pulse starting an authentication attempt
in_session  out  1  high while an authenticated session is active
locked  out  1  high in LOCKED state
entry_error  out  1  one-cycle pulse on a malformed entry
fail_count  out  4  consecutive failed attempts so far

Behaviour:
- Reset (async assert, sync release) applies these values:
  - state=IDLE
  - acc_number=0, pin=0
  - req_valid=0, in_session=0, locked=0, entry_error=0, fail_count=0
  - internal digit counter=0
- States: IDLE, ACC_ENTRY, PIN_ENTRY, REQUEST, WAIT_AUTH, SESSION, LOCKED.
- IDLE:
  - Digit key: acc_number<=digit, digit_cnt<=1, go to ACC_ENTRY.
  - All other keys are ignored.
- ACC_ENTRY:
  - Digit key with digit_cnt<ACC_DIGITS: acc<=acc*10+digit, computed in 14 bits, digit_cnt++.
  - Digit key with digit_cnt==ACC_DIGITS: ignored.
  - ENTER with digit_cnt==ACC_DIGITS and 14-bit value<=4095: go to PIN_ENTRY.
  - ENTER with value>4095: entry_error pulse, clear acc and digit_cnt, go to IDLE.
  - ENTER with digit_cnt<ACC_DIGITS: entry_error pulse, stay in ACC_ENTRY, contents unchanged.
  - CLEAR: acc<=0, digit_cnt<=0, stay in ACC_ENTRY.
  - CANCEL: go to IDLE and clear acc.
- PIN_ENTRY:
  - Digit key: pin<=digit; the last digit wins.
  - ENTER with no digit yet: entry_error pulse, stay.
  - ENTER with a digit held: go to REQUEST.
  - CLEAR: pin<=0 and the digit-held flag is cleared.
  - CANCEL: go to IDLE with acc and pin cleared.
- REQUEST: req_valid=1 for exactly one cycle, then go to WAIT_AUTH. acc_number and pin are frozen from REQUEST through SESSION.
- WAIT_AUTH:
  - Keys are ignored.
  - auth_done&auth_ok: fail_count<=0, go to SESSION.
  - auth_done&!auth_ok: fail_count++. If the new count==MAX_TRIES go to LOCKED, else go to PIN_ENTRY with pin cleared and acc kept.
  - auth_done arriving in any other state is ignored.
- SESSION:
  - in_session=1 and keys are ignored.
  - session_end=1: next cycle in_session=0, acc/pin/digit_cnt cleared, go to IDLE.
  - fail_count is not modified.
- LOCKED:
  - locked=1 and keys are ignored.
  - Counter runs LOCKOUT_CYCLES cycles, then go to IDLE with fail_count<=0.
  - session_end has no effect.
- Simultaneous events: key_valid in the same cycle as auth_done is ignored, since keys are not accepted in WAIT_AUTH. session_end outside SESSION is ignored.
- fail_count resets to 0 only on successful authentication, lockout expiry, or reset. CANCEL does not reset it.
- Reset mid-operation aborts any state immediately. No req_valid is issued after reset release until a new full entry.

Optional Feature:
ATM_KEY_TIMEOUT_EN:
- Defined:
  - An inactivity counter runs in ACC_ENTRY and PIN_ENTRY.
  - Any key_valid restarts it.
  - At TIMEOUT_CYCLES with no key: entry_error pulse, clear acc/pin/digit_cnt, go to IDLE.
  - fail_count is unchanged.
- Undefined: no counter is implemented and entry waits indefinitely. TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package atm_pkg:
  - state enum (the 7 states)
  - key code constants KEY_CLEAR=4'hA, KEY_ENTER=4'hB, KEY_CANCEL=4'hC
  - ACC_WIDTH=12, PIN_WIDTH=4
- One sub-module, atm_cycle_counter: a loadable down-counter with a done flag, shared by the lockout and timeout logic.
- The digit accumulator stays inline.

Test Plan:
- Keys 2,7,4,9,ENTER,5,ENTER; auth_done&auth_ok two cycles after req_valid
  -> acc_number=2749, pin=5, exactly one req_valid pulse, in_session=1, fail_count=0.
- Keys 9,9,9,9,ENTER
  -> entry_error pulse, state IDLE, acc_number=0, no req_valid.
- Account 2175; PIN failures three times (auth_ok=0)
  -> fail_count 1,2,3, locked=1 for 1024 cycles, keys ignored, then IDLE with fail_count=0.
- Keys 2,1,ENTER
  -> entry_error, still in ACC_ENTRY.
  - Then 7,5,ENTER,CANCEL -> IDLE, acc cleared, fail_count unchanged.
- In SESSION assert session_end
  -> next cycle in_session=0, acc_number=0, pin=0. Then assert rst_n=0 mid PIN_ENTRY -> all outputs reset immediately.
- With ATM_KEY_TIMEOUT_EN: keys 2,6; idle 4096 cycles
  -> entry_error pulse, IDLE. Without the macro, no error after 10000 cycles.
